// File: rtl/llc_stat_irq.sv
// Status latch, received-message counter and CPU interrupt for the LLC.
// The interrupt is a level signal with an acknowledge handshake and a deassert hold-off.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | irq low, waiting for an enabled status bit
// ST_ASSERT  | irq high until ack or until every pending bit is masked off
// ST_HOLD    | irq forced low after ack while the hold-off counter runs down
module llc_stat_irq #(
   parameter int CNTW    = 8,
   parameter int HOLDOFF = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            resetall,
   input  logic            activgreg,
   input  logic            activrreg,
   input  logic            sucftrano,
   input  logic            sucfrecvo,
   input  logic            overflowo,
   input  logic [2:0]      irqen,
   input  logic            ack,
   input  logic [2:0]      clr_mask,
   output logic            sucftranr,
   output logic            sucfrecvr,
   output logic            overflowr,
   output logic [CNTW-1:0] rxcount,
   output logic            irq
);

   localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
   localparam logic [CNTW-1:0] RX_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [2:0]      stat_q, stat_d;
   logic [CNTW-1:0] rx_q, rx_d;
   logic            rreg_q, rreg_d;
   logic            irq_q, irq_d;

   logic rst;
   logic rx_rise;
   logic pending;

   assign rst     = reset | ~resetall;
   assign rx_rise = activrreg & ~rreg_q;
   assign pending = |(stat_q & irqen);

   // Set is applied after clear so a same-cycle set/clear leaves the bit set.
   always_comb begin
      stat_d = stat_q;
      if (ack) begin
         stat_d = stat_d & ~clr_mask;
      end
      if (activgreg) begin
         stat_d = stat_d | {overflowo, sucfrecvo, sucftrano};
      end
   end

   always_comb begin
      rreg_d = activrreg;
      rx_d   = rx_q;
      if (ack && clr_mask[1]) begin
         rx_d = rx_rise ? {{(CNTW-1){1'b0}}, 1'b1} : '0;
      end else if (rx_rise && (rx_q != RX_MAX)) begin
         rx_d = rx_q + {{(CNTW-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (pending) begin
               state_d = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            if (ack) begin
               if (HOLDOFF > 0) begin
                  state_d = ST_HOLD;
                  hold_d  = HW'(HOLDOFF);
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (!pending) begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (hold_q != '0) begin
               hold_d = hold_q - HW'(1);
            end
            // Leave on the edge where the counter steps down to 1, so irq
            // stays low for exactly HOLDOFF cycles before IDLE can re-raise it.
            if (int'(hold_q) <= 2) begin
               state_d = ST_IDLE;
               hold_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            hold_d  = '0;
         end
      endcase
      irq_d = (state_d == ST_ASSERT);
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         stat_q  <= '0;
         rx_q    <= '0;
         rreg_q  <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         stat_q  <= stat_d;
         rx_q    <= rx_d;
         rreg_q  <= rreg_d;
         irq_q   <= irq_d;
      end
   end

   assign sucftranr = stat_q[0];
   assign sucfrecvr = stat_q[1];
   assign overflowr = stat_q[2];
   assign rxcount   = rx_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_llc_stat_irq.sv
// Directed-vector bench for llc_stat_irq (CNTW=8, HOLDOFF=2).
module tb_llc_stat_irq;

   logic       clock = 1'b0;
   logic       reset, resetall, activgreg, activrreg;
   logic       sucftrano, sucfrecvo, overflowo, ack;
   logic [2:0] irqen, clr_mask;
   logic       sucftranr, sucfrecvr, overflowr, irq;
   logic [7:0] rxcount;

   int n_vec  = 0;
   int n_fail = 0;

   llc_stat_irq #(.CNTW(8), .HOLDOFF(2)) dut (
      .clock(clock), .reset(reset), .resetall(resetall),
      .activgreg(activgreg), .activrreg(activrreg),
      .sucftrano(sucftrano), .sucfrecvo(sucfrecvo), .overflowo(overflowo),
      .irqen(irqen), .ack(ack), .clr_mask(clr_mask),
      .sucftranr(sucftranr), .sucfrecvr(sucfrecvr), .overflowr(overflowr),
      .rxcount(rxcount), .irq(irq)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst;
      logic       rall_b;
      logic       ag;
      logic       ar;
      logic [2:0] set;    // {overflowo, sucfrecvo, sucftrano}
      logic [2:0] en;
      logic       ak;
      logic [2:0] clr;
      logic [2:0] e_stat; // {overflowr, sucfrecvr, sucftranr}
      logic [7:0] e_rx;
      logic       e_irq;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic rst, logic rall_b, logic ag, logic ar,
                               logic [2:0] set, logic [2:0] en, logic ak,
                               logic [2:0] clr, logic [2:0] e_stat,
                               logic [7:0] e_rx, logic e_irq);
      vec_t v;
      v.rst = rst; v.rall_b = rall_b; v.ag = ag; v.ar = ar; v.set = set;
      v.en = en; v.ak = ak; v.clr = clr; v.e_stat = e_stat; v.e_rx = e_rx;
      v.e_irq = e_irq;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      reset     = v.rst;
      resetall  = v.rall_b;
      activgreg = v.ag;
      activrreg = v.ar;
      {overflowo, sucfrecvo, sucftrano} = v.set;
      irqen     = v.en;
      ack       = v.ak;
      clr_mask  = v.clr;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_out(input string name, input logic [2:0] e_stat,
                            input logic [7:0] e_rx, input logic e_irq);
      logic [2:0] got_stat;
      got_stat = {overflowr, sucfrecvr, sucftranr};
      n_vec++;
      if (got_stat !== e_stat || rxcount !== e_rx || irq !== e_irq) begin
         n_fail++;
         $display("FAIL %s: got stat=%b rx=%0d irq=%b, expected stat=%b rx=%0d irq=%b",
                  name, got_stat, rxcount, irq, e_stat, e_rx, e_irq);
      end
   endtask

   task automatic rx_pulse(input int hi);
      activrreg = 1'b1;
      repeat (hi) tick();
      activrreg = 1'b0;
      tick();
   endtask

   initial begin
      //              rst rb ag ar set     en      ak clr     e_stat  e_rx e_irq
      // transmit bit -> irq -> ack with hold-off
      vq.push_back(mk(1, 1, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0, 0));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b001, 0, 3'b000, 3'b000, 0, 0));
      vq.push_back(mk(0, 1, 1, 0, 3'b001, 3'b001, 0, 3'b000, 3'b001, 0, 0));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b001, 0, 3'b000, 3'b001, 0, 1));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b001, 0, 3'b000, 3'b001, 0, 1));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b001, 1, 3'b001, 3'b000, 0, 0));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b001, 0, 3'b000, 3'b000, 0, 0));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b001, 0, 3'b000, 3'b000, 0, 0));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b001, 0, 3'b000, 3'b000, 0, 0));
      // set wins over clear; rising edge together with receive clear
      vq.push_back(mk(0, 1, 1, 0, 3'b010, 3'b000, 1, 3'b010, 3'b010, 0, 0));
      vq.push_back(mk(0, 1, 0, 1, 3'b000, 3'b000, 1, 3'b010, 3'b000, 1, 0));
      vq.push_back(mk(0, 1, 0, 1, 3'b000, 3'b000, 0, 3'b000, 3'b000, 1, 0));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 1, 0));
      // partial ack leaves receive pending: 2 low cycles then re-assert
      vq.push_back(mk(0, 1, 1, 0, 3'b110, 3'b110, 0, 3'b000, 3'b110, 1, 0));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 0, 3'b000, 3'b110, 1, 1));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 1, 3'b100, 3'b010, 1, 0));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 0, 3'b000, 3'b010, 1, 0));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 0, 3'b000, 3'b010, 1, 1));
      // masking via irqen drops irq, bits kept
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b010, 1, 0));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b010, 1, 0));
      // re-enable and count up to 5
      vq.push_back(mk(0, 1, 0, 1, 3'b000, 3'b110, 0, 3'b000, 3'b010, 2, 1));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 0, 3'b000, 3'b010, 2, 1));
      vq.push_back(mk(0, 1, 0, 1, 3'b000, 3'b110, 0, 3'b000, 3'b010, 3, 1));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 0, 3'b000, 3'b010, 3, 1));
      vq.push_back(mk(0, 1, 0, 1, 3'b000, 3'b110, 0, 3'b000, 3'b010, 4, 1));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 0, 3'b000, 3'b010, 4, 1));
      vq.push_back(mk(0, 1, 0, 1, 3'b000, 3'b110, 0, 3'b000, 3'b010, 5, 1));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 0, 3'b000, 3'b010, 5, 1));
      // resetall overrides concurrent set and edge
      vq.push_back(mk(0, 0, 1, 1, 3'b111, 3'b110, 0, 3'b000, 3'b000, 0, 0));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 0, 3'b000, 3'b000, 0, 0));
      vq.push_back(mk(0, 1, 1, 1, 3'b010, 3'b110, 0, 3'b000, 3'b010, 1, 0));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 0, 3'b000, 3'b010, 1, 1));
      vq.push_back(mk(0, 1, 0, 1, 3'b000, 3'b110, 0, 3'b000, 3'b010, 2, 1));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 0, 3'b000, 3'b010, 2, 1));
      // reset overrides as well
      vq.push_back(mk(1, 1, 1, 1, 3'b111, 3'b110, 0, 3'b000, 3'b000, 0, 0));
      vq.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 0, 3'b000, 3'b000, 0, 0));

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i]);
         tick();
         check_out($sformatf("vec%0d", i), vq[i].e_stat, vq[i].e_rx, vq[i].e_irq);
      end

      // counter: multi-cycle strobes count once, then saturate
      drive(mk(1, 1, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0, 0));
      tick();
      reset = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) rx_pulse(4);
      check_out("rx_three", 3'b000, 8'd3, 1'b0);
      for (int k = 0; k < 251; k++) rx_pulse(1);
      check_out("rx_254", 3'b000, 8'd254, 1'b0);
      rx_pulse(2);
      check_out("rx_255", 3'b000, 8'd255, 1'b0);
      rx_pulse(3);
      check_out("rx_saturate", 3'b000, 8'd255, 1'b0);
      ack = 1'b1; clr_mask = 3'b010;
      tick();
      ack = 1'b0; clr_mask = 3'b000;
      check_out("rx_clear", 3'b000, 8'd0, 1'b0);

      // reset while in hold-off
      irqen = 3'b100; activgreg = 1'b1; overflowo = 1'b1;
      tick();
      activgreg = 1'b0; overflowo = 1'b0;
      tick();
      check_out("ovf_irq", 3'b100, 8'd0, 1'b1);
      ack = 1'b1; clr_mask = 3'b000;
      tick();
      ack = 1'b0;
      check_out("hold_entry", 3'b100, 8'd0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_out("hold_reset", 3'b000, 8'd0, 1'b0);
      tick();
      check_out("after_reset", 3'b000, 8'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
